// File: rtl/vram_pkg.sv
// vram_arbiter shared types and defaults.
// FSM encoding and default memory read latency.
package vram_pkg;

  localparam int RD_LAT_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_V1   = 3'd1,
    ST_V1W  = 3'd2,
    ST_V2   = 3'd3,
    ST_V2W  = 3'd4,
    ST_CW   = 3'd5,
    ST_CR   = 3'd6
  } vram_state_e;

endpackage

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one VRAM port between video pair fetches
// and CPU word accesses; video wins ties, accesses never preempt.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        vid_req,
  input  logic [18:0] vid_addr1,
  input  logic [18:0] vid_addr2,
  output logic [15:0] vid_dout1,
  output logic [15:0] vid_dout2,
  output logic        vid_done,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_be,
  input  logic [18:0] cpu_addr,
  input  logic [15:0] cpu_din,
  output logic [15:0] cpu_dout,
  output logic        cpu_ack,
  output logic [18:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [1:0]  mem_be,
  output logic [15:0] mem_din,
  input  logic [15:0] mem_dout,
  output logic        busy
);

  localparam logic [2:0] LAT    = 3'(RD_LAT);
  localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);

  vram_state_e state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        vid_req_q;
  logic        vid_pend_q, vid_pend_d;
  logic        vid_again_q, vid_again_d;
  logic [18:0] pa1_q, pa1_d;
  logic [18:0] pa2_q, pa2_d;
  logic [18:0] va2_q, va2_d;
  logic [15:0] vid_dout1_q, vid_dout1_d;
  logic [15:0] vid_dout2_q, vid_dout2_d;
  logic [15:0] cpu_dout_q, cpu_dout_d;
  logic        vid_done_q, vid_done_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic [18:0] mem_addr_q, mem_addr_d;
  logic        mem_rd_q, mem_rd_d;
  logic        mem_wr_q, mem_wr_d;
  logic [1:0]  mem_be_q, mem_be_d;
  logic [15:0] mem_din_q, mem_din_d;

  logic vid_edge;
  logic in_vid;

  assign vid_edge = vid_req ^ vid_req_q;
  assign in_vid   = (state_q == ST_V1) || (state_q == ST_V1W) ||
                    (state_q == ST_V2) || (state_q == ST_V2W);

  assign vid_dout1 = vid_dout1_q;
  assign vid_dout2 = vid_dout2_q;
  assign vid_done  = vid_done_q;
  assign cpu_dout  = cpu_dout_q;
  assign cpu_ack   = cpu_ack_q;
  assign mem_addr  = mem_addr_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_be    = mem_be_q;
  assign mem_din   = mem_din_q;
  assign busy      = (state_q != ST_IDLE);

  // Arbitration FSM and registered memory-port command generation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    vid_pend_d  = vid_pend_q | vid_edge;
    vid_again_d = vid_again_q;
    pa1_d       = pa1_q;
    pa2_d       = pa2_q;
    va2_d       = va2_q;
    vid_dout1_d = vid_dout1_q;
    vid_dout2_d = vid_dout2_q;
    cpu_dout_d  = cpu_dout_q;
    vid_done_d  = 1'b0;
    cpu_ack_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_be_d    = mem_be_q;
    mem_din_d   = mem_din_q;

    if (vid_edge) begin
      pa1_d = vid_addr1;
      pa2_d = vid_addr2;
    end
    if (vid_edge && in_vid) begin
      vid_again_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (vid_pend_q || vid_edge) begin
          state_d  = ST_V1;
          mem_rd_d = 1'b1;
          mem_be_d = 2'b11;
          if (vid_pend_q) begin
            mem_addr_d  = pa1_q;
            va2_d       = pa2_q;
            vid_again_d = vid_edge;
          end else begin
            mem_addr_d = vid_addr1;
            va2_d      = vid_addr2;
          end
        end else if (cpu_req && !cpu_ack_q) begin
          mem_addr_d = cpu_addr;
          if (cpu_we) begin
            state_d   = ST_CW;
            mem_wr_d  = 1'b1;
            mem_be_d  = cpu_be;
            mem_din_d = cpu_din;
          end else begin
            state_d  = ST_CR;
            mem_rd_d = 1'b1;
            mem_be_d = 2'b11;
            cnt_d    = LAT;
          end
        end
      end
      ST_V1: begin
        state_d = ST_V1W;
        cnt_d   = LAT_M1;
      end
      ST_V1W: begin
        if (cnt_q == 3'd0) begin
          vid_dout1_d = mem_dout;
          state_d     = ST_V2;
          mem_rd_d    = 1'b1;
          mem_addr_d  = va2_q;
          mem_be_d    = 2'b11;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_V2: begin
        state_d = ST_V2W;
        cnt_d   = LAT_M1;
      end
      ST_V2W: begin
        if (cnt_q == 3'd0) begin
          vid_dout2_d = mem_dout;
          vid_done_d  = 1'b1;
          vid_pend_d  = vid_again_q | vid_edge;
          vid_again_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_CW: begin
        cpu_ack_d = 1'b1;
        state_d   = ST_IDLE;
      end
      ST_CR: begin
        if (cnt_q == 3'd0) begin
          cpu_dout_d = mem_dout;
          cpu_ack_d  = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset; edge detector tracks vid_req
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      vid_req_q   <= vid_req;
      vid_pend_q  <= 1'b0;
      vid_again_q <= 1'b0;
      pa1_q       <= '0;
      pa2_q       <= '0;
      va2_q       <= '0;
      vid_dout1_q <= 16'h0000;
      vid_dout2_q <= 16'h0000;
      cpu_dout_q  <= 16'h0000;
      vid_done_q  <= 1'b0;
      cpu_ack_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_be_q    <= 2'b00;
      mem_din_q   <= 16'h0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vid_req_q   <= vid_req;
      vid_pend_q  <= vid_pend_d;
      vid_again_q <= vid_again_d;
      pa1_q       <= pa1_d;
      pa2_q       <= pa2_d;
      va2_q       <= va2_d;
      vid_dout1_q <= vid_dout1_d;
      vid_dout2_q <= vid_dout2_d;
      cpu_dout_q  <= cpu_dout_d;
      vid_done_q  <= vid_done_d;
      cpu_ack_q   <= cpu_ack_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_be_q    <= mem_be_d;
      mem_din_q   <= mem_din_d;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a 2-cycle-latency memory
// model that returns addr[15:0] for every read.
module tb_vram_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        vid_req = 1'b0;
  logic [18:0] vid_addr1 = '0;
  logic [18:0] vid_addr2 = '0;
  logic [15:0] vid_dout1, vid_dout2;
  logic        vid_done;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [1:0]  cpu_be = 2'b00;
  logic [18:0] cpu_addr = '0;
  logic [15:0] cpu_din = '0;
  logic [15:0] cpu_dout;
  logic        cpu_ack;
  logic [18:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [1:0]  mem_be;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;
  logic        busy;

  vram_arbiter #(.RD_LAT(2)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .vid_req(vid_req), .vid_addr1(vid_addr1),
    .vid_addr2(vid_addr2), .vid_dout1(vid_dout1),
    .vid_dout2(vid_dout2), .vid_done(vid_done),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_be(mem_be), .mem_din(mem_din),
    .mem_dout(mem_dout), .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  // memory: data valid two cycles after the strobe cycle
  logic [15:0] p1, p2;
  always @(posedge clk_sys) begin
    p1 <= mem_rd ? mem_addr[15:0] : 16'hDEAD;
    p2 <= p1;
  end
  assign mem_dout = p2;

  int total = 0;
  int bad = 0;
  int wr_cnt = 0, rd_cnt = 0, ovl = 0, be_bad = 0;
  logic [1:0]  wr_be;
  logic [15:0] wr_din;
  logic [18:0] wr_addr;

  always @(negedge clk_sys) begin
    if (mem_wr) begin
      wr_cnt  <= wr_cnt + 1;
      wr_be   <= mem_be;
      wr_din  <= mem_din;
      wr_addr <= mem_addr;
    end
    if (mem_rd) rd_cnt <= rd_cnt + 1;
    if (mem_rd && mem_be != 2'b11) be_bad <= be_bad + 1;
    if (mem_rd && mem_wr) ovl <= ovl + 1;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // ticks until vid_done or cpu_ack; 0 means timeout
  task automatic wait_evt(input bit sel_ack, output int lat);
    lat = 0;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (k == 1) begin
        vid_addr1 = 19'h55555;
        vid_addr2 = 19'h2AAAA;
      end
      if ((sel_ack ? cpu_ack : vid_done) === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  typedef struct {
    int          kind;
    logic [18:0] a1;
    logic [18:0] a2;
    logic [1:0]  be;
    logic [15:0] din;
    logic [15:0] e1;
    logic [15:0] e2;
    int          lat;
  } vec_t;

  vec_t v[7];

  initial begin
    int lat, w0, r0, td, ta, tv, nd, nb, dl, acks, derr;

    v[0] = '{0, 19'h01234, 19'h01235, 2'b00, 16'h0000,
             16'h1234, 16'h1235, 7};
    v[1] = '{1, 19'h00010, 19'h00000, 2'b01, 16'hA55A,
             16'h0000, 16'h0000, 2};
    v[2] = '{2, 19'h7ABCD, 19'h00000, 2'b00, 16'h0000,
             16'hABCD, 16'h0000, 4};
    v[3] = '{0, 19'h7FFFF, 19'h00000, 2'b00, 16'h0000,
             16'hFFFF, 16'h0000, 7};
    v[4] = '{1, 19'h40000, 19'h00000, 2'b10, 16'h1234,
             16'h0000, 16'h0000, 2};
    v[5] = '{2, 19'h00000, 19'h00000, 2'b00, 16'h0000,
             16'h0000, 16'h0000, 4};
    v[6] = '{0, 19'h3FFFE, 19'h4FFFF, 2'b00, 16'h0000,
             16'hFFFE, 16'hFFFF, 7};

    // reset state
    tick(); tick(); tick();
    chk("rst_ctl", {vid_done, cpu_ack, busy}, 0);
    chk("rst_mem", {mem_rd, mem_wr, mem_be, mem_addr, mem_din}, 0);
    chk("rst_dout", {vid_dout1, vid_dout2, cpu_dout}, 0);
    reset = 1'b0;
    tick(); tick(); tick();
    chk("idle_after_rst", {busy, mem_rd, mem_wr}, 0);

    // table vectors
    for (int i = 0; i < 7; i++) begin
      w0 = wr_cnt;
      if (v[i].kind == 0) begin
        vid_addr1 = v[i].a1;
        vid_addr2 = v[i].a2;
        vid_req = ~vid_req;
        wait_evt(1'b0, lat);
        chk($sformatf("v%0d_vid_lat", i), lat, v[i].lat);
        chk($sformatf("v%0d_dout1", i), vid_dout1, v[i].e1);
        chk($sformatf("v%0d_dout2", i), vid_dout2, v[i].e2);
      end else begin
        cpu_addr = v[i].a1;
        cpu_we = (v[i].kind == 1);
        cpu_be = v[i].be;
        cpu_din = v[i].din;
        cpu_req = 1'b1;
        wait_evt(1'b1, lat);
        cpu_req = 1'b0;
        chk($sformatf("v%0d_ack_lat", i), lat, v[i].lat);
        if (v[i].kind == 1) begin
          chk($sformatf("v%0d_wr_n", i), wr_cnt - w0, 1);
          chk($sformatf("v%0d_wr_be", i), wr_be, v[i].be);
          chk($sformatf("v%0d_wr_din", i), wr_din, v[i].din);
          chk($sformatf("v%0d_wr_addr", i), wr_addr, v[i].a1);
        end else begin
          chk($sformatf("v%0d_cpu_dout", i), cpu_dout, v[i].e1);
        end
      end
      tick(); tick();
    end

    // simultaneous video edge and CPU read: video first
    vid_addr1 = 19'h00100;
    vid_addr2 = 19'h00200;
    cpu_addr = 19'h00300;
    cpu_we = 1'b0;
    cpu_req = 1'b1;
    vid_req = ~vid_req;
    td = 0;
    ta = 0;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (vid_done === 1'b1 && td == 0) td = k;
      if (cpu_ack === 1'b1) begin
        ta = k;
        cpu_req = 1'b0;
        break;
      end
    end
    chk("sim_done_t", td, 7);
    chk("sim_ack_t", ta, 11);
    chk("sim_vid", {vid_dout1, vid_dout2}, 32'h0100_0200);
    chk("sim_cpu", cpu_dout, 16'h0300);
    tick(); tick();

    // video edge one cycle into a CPU read
    cpu_addr = 19'h00ABC;
    cpu_req = 1'b1;
    tick();
    vid_addr1 = 19'h00400;
    vid_addr2 = 19'h00500;
    vid_req = ~vid_req;
    ta = 0;
    td = 0;
    tv = 0;
    for (int k = 2; k <= 24; k++) begin
      tick();
      if (cpu_ack === 1'b1 && ta == 0) begin
        ta = k;
        cpu_req = 1'b0;
      end
      if (mem_rd === 1'b1 && mem_addr == 19'h00400 && tv == 0)
        tv = k;
      if (vid_done === 1'b1) begin
        td = k;
        break;
      end
    end
    chk("cr_ack_t", ta, 4);
    chk("cr_dout", cpu_dout, 16'h0ABC);
    chk("cr_v1_t", tv, 5);
    chk("cr_done_t", td, 11);
    chk("cr_vid", {vid_dout1, vid_dout2}, 32'h0400_0500);
    tick(); tick();

    // reset while waiting in V1W
    vid_addr1 = 19'h00777;
    vid_addr2 = 19'h00888;
    vid_req = ~vid_req;
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_ctl", {vid_done, cpu_ack, busy}, 0);
    chk("mid_rst_mem", {mem_rd, mem_wr, mem_be, mem_addr, mem_din}, 0);
    chk("mid_rst_dout", {vid_dout1, vid_dout2, cpu_dout}, 0);
    reset = 1'b0;
    r0 = rd_cnt;
    nd = 0;
    nb = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (vid_done !== 1'b0) nd++;
      if (busy !== 1'b0) nb++;
    end
    chk("mid_rst_no_done", nd, 0);
    chk("mid_rst_no_busy", nb, 0);
    chk("mid_rst_no_rd", rd_cnt - r0, 0);

    // stress: video every 32 cycles, CPU reads held on
    cpu_addr = 19'h01F0F;
    cpu_we = 1'b0;
    cpu_req = 1'b1;
    derr = 0;
    for (int p = 0; p < 6; p++) begin
      vid_addr1 = 19'(32'h100 + p);
      vid_addr2 = 19'(32'h200 + p);
      vid_req = ~vid_req;
      dl = 0;
      acks = 0;
      for (int k = 1; k <= 32; k++) begin
        tick();
        if (vid_done === 1'b1 && dl == 0) dl = k;
        if (cpu_ack === 1'b1) begin
          acks++;
          if (cpu_dout !== 16'h1F0F) derr++;
        end
      end
      chk($sformatf("st%0d_in_11", p), (dl >= 1 && dl <= 11), 1);
      chk($sformatf("st%0d_acked", p), (acks >= 1), 1);
      chk($sformatf("st%0d_vid", p), {vid_dout1, vid_dout2},
          {16'(32'h100 + p), 16'(32'h200 + p)});
    end
    cpu_req = 1'b0;
    repeat (8) tick();
    chk("st_cpu_data", derr, 0);
    chk("st_idle_end", busy, 0);

    chk("no_rd_wr_overlap", ovl, 0);
    chk("read_be_11", be_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
